hdr_flit_pck_serializer: RTL and testbench
==========================================

HDR_FLIT_PCK_SERIALIZER -- requirements
Module: hdr_flit_pck_serializer

Interface
REQ-001 Parameters SHALL be: NOC_ID 0, NoC instance select; V 4, VC count; FPAYw 32, flit payload width; LENw 6, packet-length field width; B 4, per-VC downstream buffer depth (credits); EAw 4, source address width; DAw 4, destination address width; DSTPw 4, destination port field width; Cw 1, class width; WEIGHTw 4, weight width; HDR_DATA_w 9, optional header data width.
REQ-002 Fw SHALL equal FPAYw+V+2; EAw+DAw+DSTPw+Cw+WEIGHTw+HDR_DATA_w SHALL be <= FPAYw; a violation SHALL trigger a simulation-only error and $finish.
REQ-003 Ports SHALL be (name, direction, width, meaning): clk in 1 clock; reset in 1 asynchronous active-high reset; req_valid in 1 packet request; req_ready out 1 request accepted this cycle; src_e_addr_in in EAw; dest_e_addr_in in DAw; destport_in in DSTPw; class_in in Cw; weight_in in WEIGHTw; hdr_data_in in HDR_DATA_w; vc_num_in in V one-hot target VC; pck_len_in in LENw total flits including header; data_valid in 1 body word valid; data_in in FPAYw body payload; data_ready out 1 body word consumed; credit_in in V one-hot credit return; flit_out out Fw; flit_wr out 1 flit strobe; busy out 1 packet in progress.

Function
REQ-004 Flit format SHALL be: [Fw-1:Fw-2] flags (10 header, 00 body, 01 tail, 11 single-flit); [FPAYw+V-1:FPAYw] one-hot VC; [FPAYw-1:0] payload.
REQ-005 Header payload SHALL pack LSB upward: src_e_addr, dest_e_addr, destport, class, weight, hdr_data; unused upper bits SHALL be 0.
REQ-006 FSM SHALL have states IDLE, HDR, BODY.
REQ-007 IDLE: req_ready=1; req_valid=1 latches all request fields and moves to HDR; pck_len_in of 0 SHALL be treated as 1.
REQ-008 HDR: when credit of latched VC >0, issue header flit (11 if length 1, else 10); length 1 -> IDLE, else -> BODY with remaining count = length-1.
REQ-009 BODY: a flit is issued in a cycle only when data_valid=1 and latched-VC credit >0; data_ready SHALL equal that issue condition (combinational); flags 00, or 01 when remaining count is 1; after tail -> IDLE.
REQ-010 flit_out and flit_wr SHALL be registered: a flit issued in cycle N appears with flit_wr=1 in cycle N+1; flit_wr=0 otherwise; flit_out holds its last value when flit_wr=0.
REQ-011 Per-VC credit counters (width ceil(log2(B+1))) SHALL reset to B, decrement on issue to that VC, increment on credit_in bit; simultaneous issue and credit SHALL leave the count unchanged; a credit at count B SHALL be ignored (saturate); no issue SHALL occur at count 0.
REQ-012 Credits on VCs other than the active one SHALL update independently in the same cycle.
REQ-013 req_ready SHALL be 0 outside IDLE; busy SHALL be 1 in HDR and BODY.
REQ-014 Request fields changing after acceptance SHALL not affect the packet in progress.
REQ-015 A multi-bit vc_num_in SHALL be a simulation-only error; RTL behaviour is then undefined.

Reset
REQ-016 While reset=1: state IDLE, flit_wr=0, flit_out=0, busy=0, req_ready=0, data_ready=0, all credits=B, remaining count=0.
REQ-017 Reset asserted mid-packet SHALL abort the packet with no further flits; after release, req_ready=1 from the first clk edge.

Verification
REQ-018 Length 1, vc=0001, src=3, dst=5, B=4 -> one flit, flags 11, VC field 0001, payload bits [3:0]=3, [7:4]=5; credit[0]=3.
REQ-019 Length 4, data_valid held 1 -> flags 10,00,00,01 on 4 consecutive cycles starting 1 cycle after the header issue; credit drops to 0.
REQ-020 Length 6, B=4, no credit_in -> 4 flits then stall with data_ready=0; one credit_in pulse -> exactly one more flit.
REQ-021 Credit count 0 with issue and credit_in in the same cycle is impossible; count 2 with issue and credit_in in the same cycle -> count remains 2; credit_in at count B -> stays B.
REQ-022 data_valid toggled 1,0,1,0 during body -> flits only in valid cycles; no duplicate or dropped payload words.
REQ-023 reset pulsed after 2 flits of a length-5 packet -> flit_wr=0 onward, credits=B, the next request starts with a header flit.

Source files
------------

// File: rtl/hdr_flit_pck_serializer.sv
// Packet serializer: turns a request plus a body word stream into header/body/tail
// flits for one target VC, gated by per-VC downstream credits.
module hdr_flit_pck_serializer #(
    parameter int NOC_ID     = 0,
    parameter int V          = 4,
    parameter int FPAYw      = 32,
    parameter int LENw       = 6,
    parameter int B          = 4,
    parameter int EAw        = 4,
    parameter int DAw        = 4,
    parameter int DSTPw      = 4,
    parameter int Cw         = 1,
    parameter int WEIGHTw    = 4,
    parameter int HDR_DATA_w = 9,
    parameter int Fw         = FPAYw + V + 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [EAw-1:0]        src_e_addr_in,
    input  logic [DAw-1:0]        dest_e_addr_in,
    input  logic [DSTPw-1:0]      destport_in,
    input  logic [Cw-1:0]         class_in,
    input  logic [WEIGHTw-1:0]    weight_in,
    input  logic [HDR_DATA_w-1:0] hdr_data_in,
    input  logic [V-1:0]          vc_num_in,
    input  logic [LENw-1:0]       pck_len_in,
    input  logic                  data_valid,
    input  logic [FPAYw-1:0]      data_in,
    output logic                  data_ready,
    input  logic [V-1:0]          credit_in,
    output logic [Fw-1:0]         flit_out,
    output logic                  flit_wr,
    output logic                  busy
);
    localparam int CRw  = $clog2(B + 1);
    localparam int HDRw = EAw + DAw + DSTPw + Cw + WEIGHTw + HDR_DATA_w;

    generate
        if (Fw != FPAYw + V + 2 || HDRw > FPAYw || NOC_ID < 0) begin : g_bad_params
            $fatal(1, "hdr_flit_pck_serializer: illegal parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

    state_t           state, state_nxt;
    logic [V-1:0]     vc_q;
    logic [FPAYw-1:0] hdr_q;
    logic [LENw-1:0]  rem_q;
    logic [CRw-1:0]   cred [V];
    logic             cred_ok, issue, last, accept;
    logic [1:0]       flags;
    logic [FPAYw-1:0] payload;

    always_comb begin
        cred_ok = 1'b0;
        for (int i = 0; i < V; i++)
            if (vc_q[i] && cred[i] != '0) cred_ok = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // rem_q counts flits still to send, header included, so "last" is shared by HDR and BODY
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        data_ready = 1'b0;
        busy       = 1'b0;
        issue      = 1'b0;
        accept     = 1'b0;
        flags      = 2'b00;
        payload    = data_in;
        last       = (rem_q == LENw'(1));
        case (state)
            IDLE: begin
                req_ready = ~reset;
                accept    = req_valid;
                if (req_valid) state_nxt = HDR;
            end
            HDR: begin
                busy    = 1'b1;
                payload = hdr_q;
                flags   = last ? 2'b11 : 2'b10;
                if (cred_ok) begin
                    issue     = 1'b1;
                    state_nxt = last ? IDLE : BODY;
                end
            end
            BODY: begin
                busy  = 1'b1;
                flags = last ? 2'b01 : 2'b00;
                if (data_valid && cred_ok) begin
                    issue      = 1'b1;
                    data_ready = 1'b1;
                    if (last) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vc_q     <= '0;
            hdr_q    <= '0;
            rem_q    <= '0;
            flit_wr  <= 1'b0;
            flit_out <= '0;
        end else begin
            flit_wr <= issue;
            if (accept) begin
                vc_q  <= vc_num_in;
                hdr_q <= FPAYw'({hdr_data_in, weight_in, class_in, destport_in,
                                 dest_e_addr_in, src_e_addr_in});
                rem_q <= (pck_len_in == '0) ? LENw'(1) : pck_len_in;
            end else if (issue) begin
                rem_q <= rem_q - LENw'(1);
            end
            if (issue) flit_out <= {flags, vc_q, payload};
        end
    end

    // Issue and return in the same cycle cancel; a return at full count is dropped
    for (genvar i = 0; i < V; i++) begin : g_cred
        logic dec, inc;
        assign dec = issue & vc_q[i];
        assign inc = credit_in[i];
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                cred[i] <= CRw'(B);
            else if (dec && !inc)
                cred[i] <= cred[i] - CRw'(1);
            else if (inc && !dec && cred[i] != CRw'(B))
                cred[i] <= cred[i] + CRw'(1);
        end
    end

    always @(posedge clk) begin
        if (!reset && state == IDLE && req_valid)
            assert ($onehot0(vc_num_in))
            else $error("hdr_flit_pck_serializer: vc_num_in has more than one bit set");
    end
endmodule

// File: tb/tb_hdr_flit_pck_serializer.sv
// Scoreboard bench: packets are expanded into expected flits at issue time and a
// negedge monitor pops/compares them, while tracking in-flight flits per VC.
module tb_hdr_flit_pck_serializer;
    localparam int V = 4, FPAYw = 32, LENw = 6, B = 4, EAw = 4, DAw = 4, DSTPw = 4;
    localparam int Cw = 1, WEIGHTw = 4, HDR_DATA_w = 9, Fw = FPAYw + V + 2;

    logic clk = 1'b0;
    logic reset;
    logic req_valid, req_ready, data_valid, data_ready, flit_wr, busy;
    logic [EAw-1:0] src_e_addr_in;
    logic [DAw-1:0] dest_e_addr_in;
    logic [DSTPw-1:0] destport_in;
    logic [Cw-1:0] class_in;
    logic [WEIGHTw-1:0] weight_in;
    logic [HDR_DATA_w-1:0] hdr_data_in;
    logic [V-1:0] vc_num_in, credit_in;
    logic [LENw-1:0] pck_len_in;
    logic [FPAYw-1:0] data_in;
    logic [Fw-1:0] flit_out;

    always #5 clk = ~clk;

    hdr_flit_pck_serializer #(.NOC_ID(0), .V(V), .FPAYw(FPAYw), .LENw(LENw), .B(B), .EAw(EAw),
        .DAw(DAw), .DSTPw(DSTPw), .Cw(Cw), .WEIGHTw(WEIGHTw), .HDR_DATA_w(HDR_DATA_w), .Fw(Fw)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .src_e_addr_in(src_e_addr_in), .dest_e_addr_in(dest_e_addr_in), .destport_in(destport_in),
        .class_in(class_in), .weight_in(weight_in), .hdr_data_in(hdr_data_in),
        .vc_num_in(vc_num_in), .pck_len_in(pck_len_in), .data_valid(data_valid), .data_in(data_in),
        .data_ready(data_ready), .credit_in(credit_in), .flit_out(flit_out), .flit_wr(flit_wr),
        .busy(busy));

    int checks = 0, errors = 0, cyc = 0, flits_seen = 0;
    logic [Fw-1:0] exp_q[$];
    logic [FPAYw-1:0] body_q[$];
    int fcyc[$];
    int out_cnt[V];
    logic [Fw-1:0] last_flit;
    logic [V-1:0] cr_drv, man_cr;
    bit mon_en = 0, auto_cr = 0, tog = 0;
    int vmode = 1;  // 0 random, 1 always valid, 2 alternating

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: compare flits, then account for credits returned at the same edge
    always @(negedge clk) begin
        if (mon_en) begin
            if (flit_wr) begin
                flits_seen++;
                fcyc.push_back(cyc);
                last_flit = flit_out;
                if (exp_q.size() == 0) chk("unexpected_flit", flit_out, '0);
                else chk("flit", flit_out, exp_q.pop_front());
                for (int i = 0; i < V; i++)
                    if (flit_out[FPAYw+i]) begin
                        chk("credit_overrun", out_cnt[i] < B, 1);
                        out_cnt[i]++;
                    end
            end
            for (int i = 0; i < V; i++)
                if (cr_drv[i] && out_cnt[i] > 0) out_cnt[i]--;
            if (auto_cr)
                for (int i = 0; i < V; i++)
                    cr_drv[i] = (out_cnt[i] > 0) && ($urandom_range(0, 2) == 0);
            else
                cr_drv = man_cr;
            man_cr = '0;
            credit_in = cr_drv;
        end
    end

    // Body word feeder: presents words in order, pops on handshake
    always @(negedge clk) begin
        tog = ~tog;
        if (body_q.size() == 0) data_valid = 1'b0;
        else begin
            data_valid = (vmode == 1) ? 1'b1 : (vmode == 2) ? tog : 1'($urandom_range(0, 1));
            data_in = body_q[0];
            #1;
            if (data_valid && data_ready && body_q.size() > 0) void'(body_q.pop_front());
        end
    end

    task automatic do_reset();
        reset = 1'b1; mon_en = 0; req_valid = 1'b0; credit_in = '0; man_cr = '0; cr_drv = '0;
        exp_q.delete(); body_q.delete(); fcyc.delete();
        for (int i = 0; i < V; i++) out_cnt[i] = 0;
        #1;
        chk("rst_flit_wr", flit_wr, 0);
        chk("rst_flit_out", flit_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_data_ready", data_ready, 0);
        repeat (3) @(negedge clk);
        chk("rst_flit_wr_hold", flit_wr, 0);
        reset = 1'b0; mon_en = 1;
        @(negedge clk); #2;
        chk("post_rst_req_ready", req_ready, 1);
    endtask

    task automatic send_pkt(input int len, input logic [V-1:0] vc, input int src, input int dst);
        int n, dp, cl, wt, hd;
        logic [FPAYw-1:0] hp, w;
        n = (len == 0) ? 1 : len;
        dp = $urandom_range(0, 15); cl = $urandom_range(0, 1);
        wt = $urandom_range(0, 15); hd = $urandom_range(0, 511);
        hp = FPAYw'(src) | (FPAYw'(dst) << EAw) | (FPAYw'(dp) << (EAw + DAw))
           | (FPAYw'(cl) << (EAw + DAw + DSTPw)) | (FPAYw'(wt) << (EAw + DAw + DSTPw + Cw))
           | (FPAYw'(hd) << (EAw + DAw + DSTPw + Cw + WEIGHTw));
        exp_q.push_back({(n == 1) ? 2'b11 : 2'b10, vc, hp});
        for (int k = 1; k < n; k++) begin
            w = $urandom;
            exp_q.push_back({(k == n - 1) ? 2'b01 : 2'b00, vc, w});
            body_q.push_back(w);
        end
        @(negedge clk); #2;
        req_valid = 1'b1; vc_num_in = vc; pck_len_in = LENw'(len);
        src_e_addr_in = EAw'(src); dest_e_addr_in = DAw'(dst); destport_in = DSTPw'(dp);
        class_in = Cw'(cl); weight_in = WEIGHTw'(wt); hdr_data_in = HDR_DATA_w'(hd);
        for (int t = 0; t < 500 && !req_ready; t++) begin @(negedge clk); #2; end
        chk("req_accept", req_ready, 1);
        @(negedge clk); #2;
        // scramble request fields: the packet in flight must not follow them
        req_valid = 1'b0; vc_num_in = '0; pck_len_in = LENw'($urandom);
        src_e_addr_in = EAw'($urandom); dest_e_addr_in = DAw'($urandom);
        hdr_data_in = HDR_DATA_w'($urandom);
    endtask

    task automatic wait_drain(input int limit);
        for (int t = 0; t < limit && (exp_q.size() != 0 || busy); t++) @(negedge clk);
        #2;
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    initial begin
        int base;
        logic [V-1:0] v;
        req_valid = 0; vc_num_in = '0; pck_len_in = '0; src_e_addr_in = '0; dest_e_addr_in = '0;
        destport_in = '0; class_in = '0; weight_in = '0; hdr_data_in = '0; data_in = '0;
        data_valid = 0; credit_in = '0; cr_drv = '0; man_cr = '0;
        do_reset();

        // single-flit packet
        send_pkt(1, 4'b0001, 3, 5);
        wait_drain(50);
        chk("single_flags", last_flit[Fw-1:Fw-2], 2'b11);
        chk("single_vc", last_flit[FPAYw+:V], 4'b0001);
        chk("single_src", last_flit[3:0], 3);
        chk("single_dst", last_flit[7:4], 5);

        // 4-flit packet back to back, then VC0 out of credit
        do_reset(); auto_cr = 0; vmode = 1;
        send_pkt(4, 4'b0001, $urandom_range(0, 15), $urandom_range(0, 15));
        wait_drain(50);
        chk("len4_count", fcyc.size(), 4);
        if (fcyc.size() == 4) chk("len4_consecutive", fcyc[3] - fcyc[0], 3);
        base = flits_seen;
        send_pkt(1, 4'b0001, 1, 2);
        idle(8);
        chk("zero_credit_stall", flits_seen - base, 0);
        chk("zero_credit_busy", busy, 1);
        man_cr = 4'b0001;
        wait_drain(20);
        chk("credit_release", flits_seen - base, 1);

        // saturation at B, then 6-flit packet with only B credits
        do_reset(); auto_cr = 0; vmode = 1;
        man_cr = 4'b1111; idle(2);
        man_cr = 4'b1111; idle(2);
        base = flits_seen;
        send_pkt(6, 4'b0010, 7, 9);
        idle(20);
        chk("stall_count", flits_seen - base, 4);
        chk("stall_data_ready", data_ready, 0);
        chk("stall_busy", busy, 1);
        man_cr = 4'b0010; idle(10);
        chk("one_credit_one_flit", flits_seen - base, 5);
        man_cr = 4'b0010;
        wait_drain(20);
        chk("stall_total", flits_seen - base, 6);

        // alternating data_valid
        do_reset(); auto_cr = 0; vmode = 2;
        send_pkt(4, 4'b0100, 2, 11);
        wait_drain(60);
        chk("toggle_count", fcyc.size(), 4);
        for (int k = 2; k < fcyc.size(); k++) chk("toggle_gap", (fcyc[k] - fcyc[k-1]) >= 2, 1);

        // reset in the middle of a packet
        do_reset(); auto_cr = 1; vmode = 1;
        base = flits_seen;
        send_pkt(5, 4'b1000, 4, 6);
        for (int t = 0; t < 100 && flits_seen - base < 2; t++) begin @(negedge clk); #2; end
        chk("mid_pkt_flits", flits_seen - base >= 2, 1);
        do_reset();
        base = flits_seen;
        idle(5);
        chk("abort_no_flits", flits_seen - base, 0);
        send_pkt(1, 4'b1000, 8, 3);
        wait_drain(20);
        chk("restart_header", last_flit[Fw-1:Fw-2], 2'b11);

        // random traffic with random credit return
        do_reset(); auto_cr = 1; vmode = 0;
        for (int p = 0; p < 40; p++) begin
            v = 4'b0001 << $urandom_range(0, 3);
            send_pkt($urandom_range(0, 10), v, $urandom_range(0, 15), $urandom_range(0, 15));
        end
        wait_drain(3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
